// File: rtl/wasm_operand_stack.sv
// Typed operand stack for the WASM core: top and second held in registers, deeper
// entries spilled to an array; sticky trap code freezes the stack until reset.
module wasm_operand_stack #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [2:0]            op,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  push_is64,
    output logic [WIDTH-1:0]      result,
    output logic                  result_is64,
    output logic [WIDTH-1:0]      second,
    output logic                  second_is64,
    output logic                  result_empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic [3:0]            trap
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int ARR_N = DEPTH - 2;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_BINOP = 3'd3;
    localparam logic [2:0] OP_DUP   = 3'd4;
    localparam logic [2:0] OP_SWAP  = 3'd5;

    localparam logic [3:0] TRAP_NONE  = 4'd0;
    localparam logic [3:0] TRAP_OVER  = 4'd1;
    localparam logic [3:0] TRAP_UNDER = 4'd2;
    localparam logic [3:0] TRAP_TYPE  = 4'd3;
    localparam logic [3:0] TRAP_ILL   = 4'd4;

    // i32 entries keep only the low word so tag and value always agree
    function automatic logic [WIDTH-1:0] tag_fit(input logic [WIDTH-1:0] d, input logic is64);
        logic [WIDTH-1:0] lo_mask;
        lo_mask = WIDTH'(64'h0000_0000_FFFF_FFFF);
        return is64 ? d : (d & lo_mask);
    endfunction

    logic [WIDTH-1:0] top_p0, sec_p0, top_n, sec_n;
    logic             top64_p0, sec64_p0, top64_n, sec64_n;
    logic [CNT_W-1:0] cnt_p0, cnt_n;
    logic [3:0]       trap_p0, trap_n, fault;

    logic [WIDTH-1:0] mem   [ARR_N];
    logic             mem64 [ARR_N];
    logic             wr_en;
    logic [CNT_W-1:0] rd_full, wr_full;
    logic [WIDTH-1:0] fill_v;
    logic             fill_t;

    assign rd_full = cnt_p0 - CNT_W'(3);
    assign wr_full = cnt_p0 - CNT_W'(2);

    // Refill for second comes from the array top only while it holds entries
    always_comb begin
        fill_v = '0;
        fill_t = 1'b0;
        if (cnt_p0 >= CNT_W'(3)) begin
            fill_v = mem[rd_full[DEPTH_LOG2-1:0]];
            fill_t = mem64[rd_full[DEPTH_LOG2-1:0]];
        end
    end

    always_comb begin
        fault = TRAP_NONE;
        if (op >= 3'd6)
            fault = TRAP_ILL;
        else if (((op == OP_POP || op == OP_DUP) && cnt_p0 == '0) ||
                 ((op == OP_BINOP || op == OP_SWAP) && cnt_p0 < CNT_W'(2)))
            fault = TRAP_UNDER;
        else if (op == OP_BINOP && top64_p0 != sec64_p0)
            fault = TRAP_TYPE;
        else if ((op == OP_PUSH || op == OP_DUP) && cnt_p0 == FULL)
            fault = TRAP_OVER;
    end

    always_comb begin
        top_n   = top_p0;
        top64_n = top64_p0;
        sec_n   = sec_p0;
        sec64_n = sec64_p0;
        cnt_n   = cnt_p0;
        trap_n  = trap_p0;
        wr_en   = 1'b0;
        if (op_valid && trap_p0 == TRAP_NONE) begin
            if (fault != TRAP_NONE) begin
                trap_n = fault;
            end else begin
                case (op)
                    OP_PUSH: begin
                        top_n   = tag_fit(push_data, push_is64);
                        top64_n = push_is64;
                        sec_n   = top_p0;
                        sec64_n = top64_p0;
                        wr_en   = (cnt_p0 >= CNT_W'(2));
                        cnt_n   = cnt_p0 + CNT_W'(1);
                    end
                    OP_POP: begin
                        // second is zero whenever count<=1, so popping to empty clears top
                        top_n   = sec_p0;
                        top64_n = sec64_p0;
                        sec_n   = fill_v;
                        sec64_n = fill_t;
                        cnt_n   = cnt_p0 - CNT_W'(1);
                    end
                    OP_BINOP: begin
                        top_n   = tag_fit(push_data, push_is64);
                        top64_n = push_is64;
                        sec_n   = fill_v;
                        sec64_n = fill_t;
                        cnt_n   = cnt_p0 - CNT_W'(1);
                    end
                    OP_DUP: begin
                        sec_n   = top_p0;
                        sec64_n = top64_p0;
                        wr_en   = (cnt_p0 >= CNT_W'(2));
                        cnt_n   = cnt_p0 + CNT_W'(1);
                    end
                    OP_SWAP: begin
                        top_n   = sec_p0;
                        top64_n = sec64_p0;
                        sec_n   = top_p0;
                        sec64_n = top64_p0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stage p0: architectural stack state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_p0   <= '0;
            top64_p0 <= 1'b0;
            sec_p0   <= '0;
            sec64_p0 <= 1'b0;
            cnt_p0   <= '0;
            trap_p0  <= TRAP_NONE;
        end else begin
            top_p0   <= top_n;
            top64_p0 <= top64_n;
            sec_p0   <= sec_n;
            sec64_p0 <= sec64_n;
            cnt_p0   <= cnt_n;
            trap_p0  <= trap_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_full[DEPTH_LOG2-1:0]]   <= sec_p0;
            mem64[wr_full[DEPTH_LOG2-1:0]] <= sec64_p0;
        end
    end

    assign result       = top_p0;
    assign result_is64  = top64_p0;
    assign second       = sec_p0;
    assign second_is64  = sec64_p0;
    assign count        = cnt_p0;
    assign trap         = trap_p0;
    assign result_empty = (cnt_p0 == '0);

endmodule

// File: tb/tb_wasm_operand_stack.sv
// Bench for wasm_operand_stack: directed scenarios plus randomized ops checked
// against a queue-based model of the stack and its sticky trap.
module tb_wasm_operand_stack;

    localparam int W     = 64;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          op_valid = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  push_data = '0;
    logic          push_is64 = 1'b0;
    logic [W-1:0]  result, second;
    logic          result_is64, second_is64, result_empty;
    logic [DL:0]   count;
    logic [3:0]    trap;

    wasm_operand_stack #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .push_data(push_data), .push_is64(push_is64),
        .result(result), .result_is64(result_is64),
        .second(second), .second_is64(second_is64),
        .result_empty(result_empty), .count(count), .trap(trap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: stack top is the back of the queues
    logic [63:0] mv[$];
    logic        mt[$];
    logic [3:0]  mtrap = 4'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_op(input int o, input logic [63:0] d, input logic t);
        int n;
        logic [3:0] f;
        logic [63:0] v, a;
        logic ta;
        n = mv.size();
        f = 4'd0;
        if (mtrap != 4'd0) return;
        v = t ? d : {32'h0, d[31:0]};
        if (o >= 6) f = 4'd4;
        else if (((o == 2 || o == 4) && n < 1) || ((o == 3 || o == 5) && n < 2)) f = 4'd2;
        else if (o == 3 && mt[n-1] != mt[n-2]) f = 4'd3;
        else if ((o == 1 || o == 4) && n >= DEPTH) f = 4'd1;
        if (f != 4'd0) begin
            mtrap = f;
            return;
        end
        case (o)
            1: begin mv.push_back(v); mt.push_back(t); end
            2: begin void'(mv.pop_back()); void'(mt.pop_back()); end
            3: begin
                void'(mv.pop_back()); void'(mt.pop_back());
                void'(mv.pop_back()); void'(mt.pop_back());
                mv.push_back(v); mt.push_back(t);
            end
            4: begin a = mv[n-1]; ta = mt[n-1]; mv.push_back(a); mt.push_back(ta); end
            5: begin
                a = mv[n-1]; ta = mt[n-1];
                mv[n-1] = mv[n-2]; mt[n-1] = mt[n-2];
                mv[n-2] = a; mt[n-2] = ta;
            end
            default: ;
        endcase
    endfunction

    task automatic check_all(input string ctx);
        int n;
        logic [63:0] er, es;
        logic ert, est;
        n = mv.size();
        er = '0; es = '0; ert = 1'b0; est = 1'b0;
        if (n >= 1) begin er = mv[n-1]; ert = mt[n-1]; end
        if (n >= 2) begin es = mv[n-2]; est = mt[n-2]; end
        chk({ctx, ".result"}, result, er);
        chk({ctx, ".result_is64"}, 64'(result_is64), 64'(ert));
        chk({ctx, ".second"}, second, es);
        chk({ctx, ".second_is64"}, 64'(second_is64), 64'(est));
        chk({ctx, ".empty"}, 64'(result_empty), 64'(n == 0));
        chk({ctx, ".count"}, 64'(count), 64'(n));
        chk({ctx, ".trap"}, 64'(trap), 64'(mtrap));
    endtask

    task automatic do_op(input string ctx, input int o, input logic [63:0] d,
                         input logic t, input logic v);
        op_valid  = v;
        op        = 3'(o);
        push_data = d;
        push_is64 = t;
        @(posedge clk);
        if (v) model_op(o, d, t);
        #1;
        check_all(ctx);
        op_valid = 1'b0;
        op       = 3'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mv.delete();
        mt.delete();
        mtrap = 4'd0;
        @(posedge clk);
        #1;
        check_all("rst");
        reset = 1'b1;
    endtask

    initial begin
        int r, o;
        logic t, v;
        logic [63:0] d;

        // Reset and idle
        do_reset();
        for (int i = 0; i < 4; i++) do_op("idle", 0, 64'h0, 1'b0, 1'b0);
        chk("idle.count", 64'(count), 64'd0);
        chk("idle.empty", 64'(result_empty), 64'd1);

        // i64 binop round trip
        do_op("tp2", 1, 64'h1, 1'b1, 1'b1);
        do_op("tp2", 1, 64'h1, 1'b1, 1'b1);
        do_op("tp2", 3, 64'h1, 1'b1, 1'b1);
        chk("tp2.result", result, 64'h1);
        chk("tp2.count", 64'(count), 64'd1);
        do_op("tp2pop", 2, 64'h0, 1'b0, 1'b1);
        chk("tp2pop.empty", 64'(result_empty), 64'd1);

        // i32 push masks upper bits
        do_op("tp3", 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        chk("tp3.result", result, 64'h0000_0000_FFFF_FFFF);

        // Fill to capacity, then overflow freezes the stack
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_op("fill", 1, 64'(i), 1'b1, 1'b1);
        do_op("ovf", 4, 64'h0, 1'b0, 1'b1);
        chk("ovf.trap", 64'(trap), 64'd1);
        chk("ovf.count", 64'(count), 64'd16);
        do_op("ovf.pop", 2, 64'h0, 1'b0, 1'b1);
        chk("ovf.pop.result", result, 64'd15);

        // Type mismatch
        do_reset();
        do_op("tm", 1, 64'h5, 1'b0, 1'b1);
        do_op("tm", 1, 64'h7, 1'b1, 1'b1);
        do_op("tm", 3, 64'hC, 1'b1, 1'b1);
        chk("tm.trap", 64'(trap), 64'd3);
        chk("tm.result", result, 64'h7);
        chk("tm.second", second, 64'h5);

        // Swap
        do_reset();
        do_op("sw", 1, 64'hAAAA, 1'b1, 1'b1);
        do_op("sw", 1, 64'hBBBB, 1'b0, 1'b1);
        do_op("sw", 5, 64'h0, 1'b0, 1'b1);
        chk("sw.result", result, 64'hAAAA);
        chk("sw.second", second, 64'hBBBB);

        // Underflow, then asynchronous reset between edges
        do_reset();
        do_op("unf", 2, 64'h0, 1'b0, 1'b1);
        chk("unf.trap", 64'(trap), 64'd2);
        #2;
        reset = 1'b0;
        mv.delete(); mt.delete(); mtrap = 4'd0;
        #1;
        chk("arst.trap", 64'(trap), 64'd0);
        chk("arst.count", 64'(count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        do_op("post", 1, 64'h9, 1'b1, 1'b1);
        chk("post.result", result, 64'h9);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (mtrap != 4'd0 && r < 30) begin
                do_reset();
                continue;
            end
            r = $urandom_range(0, 99);
            if (r < 35) o = 1;
            else if (r < 55) o = 2;
            else if (r < 70) o = 3;
            else if (r < 80) o = 4;
            else if (r < 90) o = 5;
            else if (r < 97) o = 0;
            else o = 6 + int'($urandom_range(0, 1));
            v = ($urandom_range(0, 49) != 0);
            d = {$urandom, $urandom};
            t = 1'(($urandom_range(0, 1)));
            if (o == 3) begin
                d = result + second;
                if ($urandom_range(0, 9) < 8) t = result_is64;
            end
            do_op("rnd", o, d, t, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wasm_operand_stack.md
Name: wasm_operand_stack

Overview:
- Parametrised operand stack for the WASM core.
- Holds typed values, configurable in width and depth, with the top two entries registered for single-cycle binary operators.
- Supersedes the fixed 64-bit, result-only stack view. Adds DUP/SWAP/binop-replace ops, an i32/i64 type tag per entry, and sticky trap reporting on the core's 4-bit trap bus.
- Sits between the core's decode/execute stage and the result/trap outputs.

Parameters:
- WIDTH, 64, entry data width in bits; must be ≥ 32.
- DEPTH_LOG2, 4, log2 of stack capacity; capacity DEPTH = 2**DEPTH_LOG2 entries.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- op_valid  input  1  op present this cycle.
- op  input  3  0=NOP, 1=PUSH, 2=POP, 3=BINOP (pop 2, push 1), 4=DUP, 5=SWAP, 6–7 reserved.
- push_data  input  WIDTH  value for PUSH / BINOP result.
- push_is64  input  1  type tag for PUSH / BINOP result; 0=i32, 1=i64.
- result  output  WIDTH  top-of-stack value.
- result_is64  output  1  type tag of top.
- second  output  WIDTH  entry below top.
- second_is64  output  1  type tag of second.
- result_empty  output  1  stack holds zero entries.
- count  output  DEPTH_LOG2+1  number of entries, 0..DEPTH.
- trap  output  4  0=none, 1=overflow, 2=underflow, 3=type mismatch, 4=illegal op.

Behaviour:
- Reset (reset=0, asynchronous): count=0, result=0, second=0, result_is64=0, second_is64=0, result_empty=1, trap=0. Array contents are don't-care.
- Ops are sampled on the rising clk edge when op_valid=1. All outputs are registered and reflect the op in the next cycle (latency 1). Back-to-back ops every cycle are legal, with no stall.
- Storage: top and second live in registers; entries 3..DEPTH live in an array indexed by count-3. Spill and fill happen in the same cycle as the op.
- PUSH:
  - Requires count<DEPTH.
  - new top=push_data (i32 entries store push_data[31:0], upper bits zeroed); old top→second; old second→array.
  - count+1.
- POP:
  - Requires count≥1.
  - second→top; array top→second; count-1.
  - When count becomes 0: result=0, result_empty=1. When count becomes 1: second=0.
- BINOP:
  - Requires count≥2 and result_is64==second_is64.
  - Both entries are removed; push_data/push_is64 becomes the new top; array top→second; count-1.
  - The caller computes push_data combinationally from result/second in the same cycle.
- DUP: requires 1≤count<DEPTH. top→second, old second→array; top unchanged; count+1.
- SWAP: requires count≥2. Exchanges top and second, including tags; count unchanged.
- Faults:
  - Overflow: PUSH or DUP at count=DEPTH → trap=1.
  - Underflow: POP at 0; BINOP or SWAP at <2; DUP at 0 → trap=2.
  - Type mismatch: BINOP with tags differing → trap=3.
  - Illegal op: op 6–7 → trap=4.
  - A faulting op leaves all stack state unchanged.
- trap is sticky. After the first non-zero code, trap holds and all further ops are ignored (stack frozen) until reset. Simultaneous fault conditions have priority illegal > underflow > type mismatch > overflow.
- op_valid=0 or NOP: no change.
- Reset asserted mid-sequence clears immediately, without waiting for clk. Ops in the first edge after reset deassertion are accepted normally.

Test Plan:
- Reset then idle 4 cycles → result=0, result_empty=1, count=0, trap=0.
- PUSH 64'h1 (i64), PUSH 64'h1 (i64), BINOP with push_data=1 (i64 eq result) → result=1, count=1, result_empty=0, trap=0. Then POP → result=0, result_empty=1.
- PUSH 32'hFFFF_FFFF with push_is64=0 and upper push_data bits set → result=64'h0000_0000_FFFF_FFFF, result_is64=0.
- PUSH DEPTH=16 values 0..15, then DUP → trap=1, count=16, result=15. Pop attempts then ignored, result stays 15.
- PUSH i32 5, PUSH i64 7, BINOP → trap=3, count=2, result=7, second=5. Separately: SWAP on a 2-entry stack {A,B} → result=A, second=B.
- POP on empty → trap=2. Assert reset asynchronously mid-clock → trap=0, count=0 before the next edge. Then PUSH 9 → result=9.
